uart_tx_fifo_drain: RTL
=======================

# uart_tx_fifo_drain

UART transmitter that drains the byte FIFO from its read side. When enabled and the FIFO is non-empty, it pops one word, then serializes it as an 8N1-style frame on `tx`: one start bit, data LSB-first, and 1 or 2 stop bits. Consecutive frames are sent back-to-back with no idle gap. It is the reader to the FIFO's writer and sits between the FIFO and the board's UART TX pin.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of each FIFO word and of the frame's data field (1..16).
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (≥2); 868 gives 115200 baud from 100 MHz.
- `STOP_BITS`, 1, number of stop bits (1 or 2).

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits new frames to start; an in-flight frame always completes.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  DATA_WIDTH  FIFO head word (fall-through: valid whenever `!fifo_empty`).
- `fifo_pop`  out  1  one-cycle pop strobe; the FIFO advances on the same edge.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in flight (START..STOP).
- `tx_done`  out  1  one-cycle pulse during the last cycle of a frame's final stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
- Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1. Bit index: $clog2(DATA_WIDTH) bits, or 1 bit if DATA_WIDTH=1. Stop counter: 1 bit.
- The pop condition is `enable && !fifo_empty` while in IDLE, or in the last cycle of the final stop bit.
- `fifo_pop` is combinational from state, counters, `enable` and `fifo_empty`. It is never asserted while `fifo_empty`=1.
- On the edge where `fifo_pop`=1:
  - the shift register loads `fifo_data`;
  - the baud counter clears;
  - the next state is START.
- IDLE: `tx`=1, `busy`=0. `fifo_data` is ignored whenever `fifo_empty`=1.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: `tx` = shift register bit 0 for CLKS_PER_BIT cycles per bit. At the end of each bit, shift right. After bit DATA_WIDTH-1, go to STOP.
- STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. In the final cycle:
  - `tx_done`=1;
  - if the pop condition holds, pop and go to START;
  - otherwise go to IDLE.
- `enable` falling mid-frame does not abort the frame. No further pop occurs after the frame ends.
- `tx` is registered (glitch-free). `busy` = (state ≠ IDLE).

## Timing
- Reset values: `tx`=1, `busy`=0, `tx_done`=0, `fifo_pop`=0, state IDLE, all counters 0.
- Reset mid-frame: `tx` is 1 on the next cycle and the state is IDLE. The popped word is discarded, not replayed. `reset` has priority over a pop in the same cycle.
- Pop-to-start latency: `fifo_pop` is high in cycle N; `tx` falls in cycle N+1.
- Frame length: exactly (1 + DATA_WIDTH + STOP_BITS) × CLKS_PER_BIT cycles, measured from the `tx` fall to the end of the stop bit.
- Back-to-back: the next start bit begins immediately after the last stop cycle, with zero idle cycles.
- Steady-state throughput is one word per frame length; `fifo_pop` pulses are spaced exactly one frame apart.
- `fifo_empty` deasserting in the final stop cycle is accepted that cycle (zero gap).
- `enable` is sampled only at pop opportunities.

## Test plan
Use CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1 unless stated.
- Reset, then hold `fifo_empty`=1 for 100 cycles → `tx`=1, `fifo_pop`=0 and `busy`=0 throughout.
- Single word 0xA5, `enable`=1 → one `fifo_pop` pulse; `tx` sequence (4 cycles each) is 0,1,0,1,0,0,1,0,1,1 (start bit, LSB-first data, stop bit); `tx_done` pulses at cycle 40 after the `tx` fall; the block returns to IDLE.
- Three words 0x00, 0xFF, 0x3C queued → `fifo_pop` pulses exactly 40 cycles apart; no high gap between stop and start bits; each frame decodes correctly.
- STOP_BITS=2, word 0x81 → the stop field is 8 cycles high; `tx_done` falls at cycle 44 of the frame.
- `enable` dropped in the middle of the first of two queued frames → the first frame completes; no second pop; `tx` stays 1.
- `reset` asserted during the DATA state of frame 1 → the next cycle shows `tx`=1 and `busy`=0; after release with the FIFO non-empty, the next word is sent intact.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1-style transmitter that pops words from a fall-through FIFO and sends them back-to-back.
// Latency: fifo_pop in cycle N, start bit on tx from cycle N+1; frame = (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: pops only at frame boundaries while enable && !fifo_empty; an in-flight frame always completes.
`timescale 1ns/1ps
module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         baud_cnt, baud_cnt_n;
    logic [BW-1:0]         bit_idx, bit_idx_n;
    logic                  stop_cnt, stop_cnt_n;
    logic [DATA_WIDTH-1:0] shift_q, shift_n;
    logic                  tx_n;
    logic                  baud_end;
    logic                  frame_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            shift_q  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            stop_cnt <= stop_cnt_n;
            shift_q  <= shift_n;
            tx       <= tx_n;
        end
    end

    always_comb begin
        baud_end   = (baud_cnt == BAUD_LAST);
        frame_end  = (state == STOP) && baud_end && (stop_cnt == STOP_LAST);
        // Reset wins over a pop so no word leaves the FIFO while the frame would be discarded.
        fifo_pop   = !reset && enable && !fifo_empty && ((state == IDLE) || frame_end);
        tx_done    = frame_end;
        busy       = (state != IDLE);

        state_n    = state;
        baud_cnt_n = baud_cnt + 1'b1;
        bit_idx_n  = bit_idx;
        stop_cnt_n = stop_cnt;
        shift_n    = shift_q;

        case (state)
            IDLE: baud_cnt_n = '0;
            START: begin
                if (baud_end) begin
                    state_n    = DATA;
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    shift_n    = shift_q >> 1;
                    if (bit_idx == BIT_LAST) begin
                        state_n    = STOP;
                        stop_cnt_n = 1'b0;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    if (frame_end) state_n = IDLE;
                    else           stop_cnt_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (fifo_pop) begin
            state_n    = START;
            baud_cnt_n = '0;
            shift_n    = fifo_data;
        end

        // tx is registered from the next-state view so the line changes cleanly on the clock edge.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end
endmodule
